// File: rtl/dig_pkg.sv
// ============================================================================
//  dig_pkg : shared cell codes, grid sizes and scan FSM states for the
//            Digger playfield logic.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package dig_pkg;
   localparam int GRID_W = 16;
   localparam int GRID_H = 16;
   localparam int CELL_W = 3;
   localparam int ADDR_W = 8;

   localparam logic [CELL_W-1:0] CELL_OPEN = 3'd0;
   localparam logic [CELL_W-1:0] CELL_DIRT = 3'd1;
   localparam logic [CELL_W-1:0] CELL_EDGE = 3'd2;

   typedef enum logic [2:0] {
      INIT = 3'd0,
      DRD  = 3'd1,
      DWR  = 3'd2,
      QU   = 3'd3,
      QD   = 3'd4,
      QL   = 3'd5,
      QR   = 3'd6,
      PUB  = 3'd7
   } state_t;
endpackage

`default_nettype wire

// File: rtl/tunnel_ram.sv
// ============================================================================
//  tunnel_ram : 256 x 3 single-port RAM, synchronous read, write-enable.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tunnel_ram
   import dig_pkg::*;
(
   input  logic              Clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [CELL_W-1:0] wdata,
   output logic [CELL_W-1:0] rdata
);

   logic [CELL_W-1:0] mem [0:GRID_W*GRID_H-1];

   // Read-before-write; no reset so the array maps onto RAM primitives.
   always_ff @(posedge Clk) begin
      if (we)
         mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

`default_nettype wire

// File: rtl/tunnel_map.sv
// ============================================================================
//  tunnel_map : playfield store; carves the digger cell and publishes the
//               gobblin's four neighbour codes once per 7-cycle scan.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tunnel_map
   import dig_pkg::*;
#(
   parameter logic [3:0] OPEN_ROW = 4'd0
)(
   input  logic              Clk,
   input  logic              rst,
   input  logic [3:0]        Digx,
   input  logic [3:0]        Digy,
   input  logic [3:0]        Gx,
   input  logic [3:0]        Gy,
   output logic [CELL_W-1:0] up,
   output logic [CELL_W-1:0] down,
   output logic [CELL_W-1:0] left,
   output logic [CELL_W-1:0] right,
   output logic              map_ready,
   output logic [8:0]        dug_count
);

   state_t            state;
   logic [ADDR_W-1:0] init_addr;
   logic [3:0]        dx, dy, gx, gy;
   logic [CELL_W-1:0] sh_up, sh_down, sh_left;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [CELL_W-1:0] ram_wdata;
   logic [CELL_W-1:0] ram_rdata;

   logic              up_off, down_off, left_off, right_off;
   logic [3:0]        gx_dec, gx_inc, gy_dec, gy_inc;

   assign up_off    = (gx == 4'd0);
   assign down_off  = (gx == 4'd15);
   assign left_off  = (gy == 4'd0);
   assign right_off = (gy == 4'd15);
   assign gx_dec    = gx - 4'd1;
   assign gx_inc    = gx + 4'd1;
   assign gy_dec    = gy - 4'd1;
   assign gy_inc    = gy + 4'd1;

   // Off-grid neighbours park on the gobblin's own cell; the data is discarded.
   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = {gx, gy};
      ram_wdata = CELL_OPEN;
      case (state)
         INIT: begin
            ram_we    = 1'b1;
            ram_addr  = init_addr;
            ram_wdata = (init_addr[7:4] == OPEN_ROW) ? CELL_OPEN : CELL_DIRT;
         end
         DRD:  ram_addr = {dx, dy};
         DWR: begin
            ram_we   = 1'b1;
            ram_addr = {dx, dy};
         end
         QU:      ram_addr = up_off    ? {gx, gy} : {gx_dec, gy};
         QD:      ram_addr = down_off  ? {gx, gy} : {gx_inc, gy};
         QL:      ram_addr = left_off  ? {gx, gy} : {gx, gy_dec};
         QR:      ram_addr = right_off ? {gx, gy} : {gx, gy_inc};
         default: ram_addr = {gx, gy};
      endcase
   end

   tunnel_ram u_ram (
      .Clk   (Clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge Clk) begin
      if (rst) begin
         state     <= INIT;
         init_addr <= '0;
         up        <= CELL_EDGE;
         down      <= CELL_EDGE;
         left      <= CELL_EDGE;
         right     <= CELL_EDGE;
         sh_up     <= CELL_EDGE;
         sh_down   <= CELL_EDGE;
         sh_left   <= CELL_EDGE;
         map_ready <= 1'b0;
         dug_count <= '0;
         dx        <= '0;
         dy        <= '0;
         gx        <= '0;
         gy        <= '0;
      end else begin
         case (state)
            INIT: begin
               init_addr <= init_addr + 8'd1;
               if (init_addr == 8'd255) begin
                  state     <= DRD;
                  map_ready <= 1'b1;
                  dx        <= Digx;
                  dy        <= Digy;
                  gx        <= Gx;
                  gy        <= Gy;
               end
            end
            DRD: state <= DWR;
            DWR: begin
               if (ram_rdata == CELL_DIRT && dug_count != 9'd256)
                  dug_count <= dug_count + 9'd1;
               state <= QU;
            end
            QU: state <= QD;
            QD: begin
               sh_up <= up_off ? CELL_EDGE : ram_rdata;
               state <= QL;
            end
            QL: begin
               sh_down <= down_off ? CELL_EDGE : ram_rdata;
               state   <= QR;
            end
            QR: begin
               sh_left <= left_off ? CELL_EDGE : ram_rdata;
               state   <= PUB;
            end
            PUB: begin
               up    <= sh_up;
               down  <= sh_down;
               left  <= sh_left;
               right <= right_off ? CELL_EDGE : ram_rdata;
               dx    <= Digx;
               dy    <= Digy;
               gx    <= Gx;
               gy    <= Gy;
               state <= DRD;
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_tunnel_map.sv
// ============================================================================
//  tb_tunnel_map : directed self-checking bench for tunnel_map.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tunnel_map;

   logic       Clk = 1'b0;
   logic       rst;
   logic [3:0] Digx, Digy, Gx, Gy;
   logic [2:0] up, down, left, right;
   logic       map_ready;
   logic [8:0] dug_count;

   int total = 0;
   int bad   = 0;

   tunnel_map #(.OPEN_ROW(4'd0)) dut (
      .Clk       (Clk),
      .rst       (rst),
      .Digx      (Digx),
      .Digy      (Digy),
      .Gx        (Gx),
      .Gy        (Gy),
      .up        (up),
      .down      (down),
      .left      (left),
      .right     (right),
      .map_ready (map_ready),
      .dug_count (dug_count)
   );

   always #5 Clk = ~Clk;

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [2:0] eu, input logic [2:0] ed,
                       input logic [2:0] el, input logic [2:0] er);
      chk({tag, ".up"},    {6'd0, up},    {6'd0, eu});
      chk({tag, ".down"},  {6'd0, down},  {6'd0, ed});
      chk({tag, ".left"},  {6'd0, left},  {6'd0, el});
      chk({tag, ".right"}, {6'd0, right}, {6'd0, er});
   endtask

   initial begin
      rst = 1'b1; Digx = 4'd0; Digy = 4'd3; Gx = 4'd0; Gy = 4'd14;
      tick(3);
      chk("rst.ready", {8'd0, map_ready}, 9'd0);
      chk("rst.dug", dug_count, 9'd0);
      chk4("rst", 3'd2, 3'd2, 3'd2, 3'd2);
      rst = 1'b0;

      // Initialisation: ready rises on the 256th edge after release.
      tick(255);
      chk("init.ready_lo", {8'd0, map_ready}, 9'd0);
      chk4("init", 3'd2, 3'd2, 3'd2, 3'd2);
      tick(1);
      chk("init.ready_hi", {8'd0, map_ready}, 9'd1);
      tick(6);
      chk4("prepub", 3'd2, 3'd2, 3'd2, 3'd2);
      tick(1);
      chk4("pub0", 3'd2, 3'd1, 3'd0, 3'd0);
      chk("openrow.dug", dug_count, 9'd0);

      // Gobblin at (4,5), digger still in the open row.
      Gx = 4'd4; Gy = 4'd5;
      tick(14);
      chk4("g45", 3'd1, 3'd1, 3'd1, 3'd1);

      // Digger onto the gobblin's lower neighbour.
      Digx = 4'd5; Digy = 4'd5;
      tick(7);
      chk("dig.before", dug_count, 9'd0);
      chk("dig.down_before", {6'd0, down}, 9'd1);
      tick(2);
      chk("dig.after_dwr", dug_count, 9'd1);
      tick(5);
      chk4("dig.pub", 3'd1, 3'd0, 3'd1, 3'd1);
      tick(70);
      chk("dig.held", dug_count, 9'd1);
      chk("dig.held_down", {6'd0, down}, 9'd0);

      // Corners: no neighbour may wrap.
      Gx = 4'd15; Gy = 4'd15;
      tick(14);
      chk4("g1515", 3'd1, 3'd2, 3'd1, 3'd2);
      Gx = 4'd0; Gy = 4'd0;
      tick(14);
      chk4("g00", 3'd2, 3'd1, 3'd2, 3'd0);

      Gx = 4'd4; Gy = 4'd5;
      Digx = 4'd7; Digy = 4'd7;
      tick(14);
      chk("dig2", dug_count, 9'd2);
      Digx = 4'd9; Digy = 4'd9;
      tick(14);
      chk("dig3", dug_count, 9'd3);

      // Four edges after a publish the scan sits in QL.
      tick(4);
      rst = 1'b1; Digx = 4'd0; Digy = 4'd3;
      tick(1);
      chk("midrst.ready", {8'd0, map_ready}, 9'd0);
      chk("midrst.dug", dug_count, 9'd0);
      chk4("midrst", 3'd2, 3'd2, 3'd2, 3'd2);
      rst = 1'b0;
      tick(256);
      chk("reinit.ready", {8'd0, map_ready}, 9'd1);
      tick(7);
      chk4("reinit.pub", 3'd1, 3'd1, 3'd1, 3'd1);
      chk("reinit.dug", dug_count, 9'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/tunnel_map.md
# tunnel_map

Playfield occupancy store for the Digger game. It holds a 16×16 grid of cell codes, carves the digger's current cell into tunnel, and repeatedly looks up the four neighbours of the gobblin's position. It produces the registered `up`/`down`/`left`/`right` blocking codes that the gobblin move logic consumes, where 0 means passable. It sits directly upstream of the gobblin and beside the digger controller.

## Interface
Parameters:
- `OPEN_ROW`, default 4'd0: row index carved open during map initialisation (gobblin start row).

Ports:
- `Clk`  in  1  system clock; all state changes on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `Digx`  in  4  digger row (x; up = x−1).
- `Digy`  in  4  digger column (y; left = y−1).
- `Gx`  in  4  gobblin row.
- `Gy`  in  4  gobblin column.
- `up`  out  3  code of cell (Gx−1, Gy).
- `down`  out  3  code of cell (Gx+1, Gy).
- `left`  out  3  code of cell (Gx, Gy−1).
- `right`  out  3  code of cell (Gx, Gy+1).
- `map_ready`  out  1  high once initialisation is complete.
- `dug_count`  out  9  number of dirt cells converted to tunnel by the digger since reset.

## Operation
- Cell codes (3 bits):
  - 3'd0 OPEN: tunnel.
  - 3'd1 DIRT.
  - 3'd2 EDGE: off-grid; never stored.
  - 3'd3–3'd7: reserved; treated as blocking.
- Storage: 256 × 3 single-port RAM.
  - Address = {row, col}.
  - Read is synchronous: data is valid the cycle after the address is presented.
- FSM states: INIT, DRD, DWR, QU, QD, QL, QR, PUB.
- INIT:
  - Writes one cell per cycle, address 0..255.
  - Cells with row == OPEN_ROW get OPEN; all others get DIRT.
  - After address 255 is written, go to DRD.
- Coordinate latch: Digx, Digy, Gx, Gy are registered on every edge entering DRD. The whole scan uses only these latched values.
- DRD: read address {Dx, Dy}.
- DWR:
  - Write OPEN to {Dx, Dy}.
  - If the read data == DIRT, increment `dug_count`. It saturates at 256.
- QU, QD, QL, QR: present the up, down, left and right neighbour addresses in turn.
  - Each state captures the previous state's read data into a shadow register. QD captures up, QL captures down, QR captures left, PUB captures right.
- Off-grid neighbours force the shadow value to EDGE regardless of RAM data:
  - up off-grid when Gx == 0;
  - down off-grid when Gx == 15;
  - left off-grid when Gy == 0;
  - right off-grid when Gy == 15.
  - Neighbour arithmetic is 4-bit. The off-grid test is made before the increment/decrement, so wrap-around is never used as an address.
- PUB:
  - All four outputs load from the shadow registers on the same edge.
  - Next state is DRD. The loop period is 7 cycles.
- Digger on the gobblin's neighbour cell: that cell was written in DWR earlier in the same scan, so it reports OPEN.
- Digger cell equal to the gobblin cell: no special case.

## Timing
- Reset values, applied on the rst edge:
  - state = INIT, INIT address = 0;
  - up/down/left/right = 3'd2;
  - map_ready = 0;
  - dug_count = 0.
- Reset mid-operation: the same values apply and INIT restarts at address 0. Any in-flight scan is discarded.
- Outputs hold EDGE throughout INIT, so the gobblin cannot move until the first PUB.
- map_ready rises on the edge entering the first DRD, 256 edges after reset is released. It stays high until the next rst.
- Outputs change only on the PUB→DRD edge, once every 7 cycles. They are stable in between.
- Latency from coordinate latch to published codes: 7 cycles.
- Latency from digger arrival to carved cell: at most 7 cycles to the latch, plus 2 cycles.
- dug_count updates on the DWR edge, once per scan at most.

## Structure
- Shared package `dig_pkg`:
  - code constants CELL_OPEN, CELL_DIRT, CELL_EDGE;
  - the FSM state enum;
  - grid constants GRID_W = 16, GRID_H = 16, CELL_W = 3.
- One sub-module, `tunnel_ram`: 256×3 single-port RAM with synchronous read and write-enable, inferable as distributed or block RAM. The FSM, shadow registers and counter stay in tunnel_map.

## Test plan
- Reset released, Gx/Gy = 0/14 held: map_ready low for 256 cycles with all outputs 3'd2. The first publish, 7 cycles later, gives up = 2, down = 1, left = 0, right = 0.
- Digger at (5,5) after ready: dug_count goes 0 → 1 on the first DWR. It remains 1 over 10 further scans with the digger held.
- Digger at (0,3), inside the open row: dug_count stays 0.
- Gobblin at (4,5), digger moved to (5,5): the next publish shows down = 0. Before the dig, down = 1.
- Gobblin at (15,15): down = 2 and right = 2. Gobblin at (0,0): up = 2 and left = 2. No neighbour wraps to row/col 15 or 0.
- rst asserted during QL with dug_count = 3: next cycle outputs = 2, map_ready = 0, dug_count = 0. The cell previously dug at (5,5) reads DIRT after re-init.
